irq_flag_ctrl: RTL and testbench

IRQ_FLAG_CTRL -- requirements
Module: irq_flag_ctrl

---
 rtl/irq_flag_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_irq_flag_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_flag_ctrl.sv
// Interrupt flag controller: synchronizes raw flag sources, captures them into
// sticky pending bits, masks them with an enable register and runs a small
// request/acknowledge handshake towards the core for the lowest-numbered
// enabled pending source. A simple select/strobe bus gives register access.
module irq_flag_ctrl #(
    parameter int N_SRC = 8,
    parameter int EDGE  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         src_in,
    input  logic                     bus_cs,
    input  logic                     bus_wr,
    input  logic                     bus_rd,
    input  logic [1:0]               bus_addr,
    input  logic [31:0]              bus_wdata,
    output logic [31:0]              bus_rdata,
    output logic                     bus_ready,
    output logic                     irq_req,
    input  logic                     irq_ack,
    output logic [$clog2(N_SRC)-1:0] irq_id
);

    localparam int IDW = $clog2(N_SRC);

    // Registers are kept 32 bits wide; bits at and above N_SRC are forced to 0
    localparam logic [31:0] SRC_MASK = (N_SRC >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << N_SRC) - 32'd1);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_ACTIVE  = 2'd2;
    localparam logic [1:0] ADDR_FORCE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;
    logic [N_SRC-1:0] hist;
    logic [31:0]      pending;
    logic [31:0]      enable;
    logic [31:0]      capture;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;
    logic [31:0]      pending_next;
    logic [31:0]      active_req;
    logic [31:0]      rd_word;
    logic [31:0]      rd_stage;
    logic             acc_stage;
    logic             is_write;
    logic             is_read;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   lowest_id;

    // A simultaneous write and read strobe is handled as a plain write
    assign is_write = bus_cs & bus_wr;
    assign is_read  = bus_cs & bus_rd & ~bus_wr;
    assign irq_id   = id;

    // Two-flop synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= src_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Capture events, software set/clear, and the lowest enabled pending index
    always_comb begin
        capture = '0;
        if (EDGE != 0) begin
            capture[N_SRC-1:0] = sync2 & ~hist;
        end else begin
            capture[N_SRC-1:0] = sync2;
        end
        set_mask     = capture | ((is_write && bus_addr == ADDR_FORCE) ? bus_wdata : 32'd0);
        clr_mask     = (is_write && bus_addr == ADDR_PENDING) ? bus_wdata : 32'd0;
        pending_next = ((pending & ~clr_mask) | set_mask) & SRC_MASK;
        active_req   = pending & enable;
        lowest_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active_req[i]) begin
                lowest_id = IDW'(i);
            end
        end
    end

    // Read data is taken from the register state seen in the access cycle
    always_comb begin
        rd_word = '0;
        if (is_read) begin
            case (bus_addr)
                ADDR_PENDING: rd_word = pending;
                ADDR_ENABLE:  rd_word = enable;
                ADDR_ACTIVE: begin
                    rd_word[31]      = (state != IDLE);
                    rd_word[IDW-1:0] = id;
                end
                default:      rd_word = '0;
            endcase
        end
    end

    // Pending and enable registers; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            enable  <= '0;
        end else begin
            pending <= pending_next;
            if (is_write && bus_addr == ADDR_ENABLE) begin
                enable <= bus_wdata & SRC_MASK;
            end
        end
    end

    // Two-stage bus response: ready and data appear one cycle after the access edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_stage <= 1'b0;
            rd_stage  <= '0;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            acc_stage <= is_write | is_read;
            rd_stage  <= rd_word;
            bus_ready <= acc_stage;
            bus_rdata <= acc_stage ? rd_stage : 32'd0;
        end
    end

    // Request handshake; the latched id is cleared whenever the FSM returns to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            id      <= '0;
            irq_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (active_req != 32'd0) begin
                        state   <= REQ;
                        id      <= lowest_id;
                        irq_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (!enable[id] || !pending[id]) begin
                        state   <= IDLE;
                        id      <= '0;
                        irq_req <= 1'b0;
                    end else if (irq_ack) begin
                        state   <= SERVICE;
                        irq_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    irq_req <= 1'b0;
                    if (!pending[id]) begin
                        state <= IDLE;
                        id    <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    id      <= '0;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_flag_ctrl.sv
// Self-checking bench for irq_flag_ctrl: directed bus/flag sequences with a
// scoreboard queue of expected bus read data checked by a separate monitor.
module tb_irq_flag_ctrl;

    localparam int N_SRC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src_in;
    logic        bus_cs;
    logic        bus_wr;
    logic        bus_rd;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        irq_req;
    logic        irq_ack;
    logic [2:0]  irq_id;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    irq_flag_ctrl #(.N_SRC(N_SRC), .EDGE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_in    (src_in),
        .bus_cs    (bus_cs),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .irq_req   (irq_req),
        .irq_ack   (irq_ack),
        .irq_id    (irq_id)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: pops one expected word per bus_ready, otherwise rdata must be 0
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    checkOutput(name_q.pop_front(), bus_rdata, exp_q.pop_front());
                end
            end else begin
                checkOutput("rdata_idle_zero", bus_rdata, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                                 input logic [1:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expected, input string name);
        if (cs && (wr || rd)) begin
            exp_q.push_back(expected);
            name_q.push_back(name);
        end
        bus_cs    = cs;
        bus_wr    = wr;
        bus_rd    = rd;
        bus_addr  = addr;
        bus_wdata = wdata;
        tick();
        bus_cs    = 1'b0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_wdata = 32'd0;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data, input string name);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, data, 32'd0, name);
    endtask

    task automatic busRead(input logic [1:0] addr, input logic [31:0] expected, input string name);
        applyStimulus(1'b1, 1'b0, 1'b1, addr, 32'd0, expected, name);
    endtask

    task automatic waitIrq(input string name, input int max_cycles);
        int n = 0;
        while (irq_req !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, irq_req}, 32'd1);
    endtask

    task automatic ackOnce();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        int n;
        rst_n     = 1'b1;
        src_in    = '0;
        bus_cs    = 1'b0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        irq_ack   = 1'b0;
        #2 rst_n = 1'b0;
        idle(3);
        checkOutput("reset_irq_req",   {31'd0, irq_req},   32'd0);
        checkOutput("reset_irq_id",    {29'd0, irq_id},    32'd0);
        checkOutput("reset_bus_ready", {31'd0, bus_ready}, 32'd0);
        checkOutput("reset_bus_rdata", bus_rdata,          32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single-cycle pulse on source 0: pending at 3rd edge, request one edge later
        busWrite(2'd1, 32'h01, "wr_enable_01");
        src_in = 8'h01;
        tick();
        src_in = 8'h00;
        tick();
        tick();
        checkOutput("pulse_no_req_yet", {31'd0, irq_req}, 32'd0);
        busRead(2'd0, 32'h01, "pulse_pending");
        checkOutput("pulse_irq_req", {31'd0, irq_req}, 32'd1);
        checkOutput("pulse_irq_id",  {29'd0, irq_id},  32'd0);
        ackOnce();
        checkOutput("service_req_low", {31'd0, irq_req}, 32'd0);
        busRead(2'd2, 32'h8000_0000, "service_active");
        busWrite(2'd0, 32'h01, "w1c_src0");
        idle(1);
        busRead(2'd2, 32'h0000_0000, "idle_active");

        // Two sources rising together: lowest index first, then back-to-back
        busWrite(2'd1, 32'hFF, "wr_enable_ff");
        src_in = 8'h24;
        idle(3);
        waitIrq("prio_req", 4);
        checkOutput("prio_first_id", {29'd0, irq_id}, 32'd2);
        ackOnce();
        busWrite(2'd0, 32'h04, "w1c_src2");
        tick();
        checkOutput("b2b_idle_req_low", {31'd0, irq_req}, 32'd0);
        tick();
        checkOutput("b2b_req_again", {31'd0, irq_req}, 32'd1);
        checkOutput("b2b_second_id", {29'd0, irq_id},  32'd5);
        ackOnce();
        busWrite(2'd0, 32'h20, "w1c_src5");
        idle(2);
        busRead(2'd0, 32'h00, "held_high_no_recapture");
        src_in = 8'h00;
        idle(3);

        // Capture and write-1-to-clear on the same edge: the capture survives
        src_in = 8'h08;
        tick();
        tick();
        busWrite(2'd0, 32'h08, "w1c_race_src3");
        busRead(2'd0, 32'h08, "set_wins_pending");
        checkOutput("set_wins_irq_req", {31'd0, irq_req}, 32'd1);
        checkOutput("set_wins_irq_id",  {29'd0, irq_id},  32'd3);
        ackOnce();
        busWrite(2'd0, 32'h08, "w1c_src3");
        tick();
        src_in = 8'h00;
        busRead(2'd0, 32'h00, "src3_cleared");
        idle(2);

        // Disabling the requested source withdraws the request without ack
        src_in = 8'h02;
        idle(3);
        waitIrq("disable_req", 4);
        checkOutput("disable_req_id", {29'd0, irq_id}, 32'd1);
        busWrite(2'd1, 32'h00, "wr_enable_00");
        checkOutput("disable_req_still", {31'd0, irq_req}, 32'd1);
        tick();
        checkOutput("disable_req_dropped", {31'd0, irq_req}, 32'd0);
        busRead(2'd2, 32'h0000_0000, "disable_active");
        busRead(2'd0, 32'h02, "disable_pending_sticky");
        busWrite(2'd0, 32'h02, "w1c_src1");
        src_in = 8'h00;
        idle(2);

        // Unimplemented bits ignored, simultaneous strobes act as a write
        busWrite(2'd1, 32'hFFFF_FFFF, "wr_enable_all");
        busRead(2'd1, 32'h0000_00FF, "enable_upper_bits");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 32'h0, 32'h0, "wr_rd_both_rdata");
        busRead(2'd1, 32'h0000_0000, "wr_rd_both_is_write");
        idle(2);

        // Software force followed by enable
        busWrite(2'd3, 32'h80, "force_80");
        busWrite(2'd1, 32'h80, "wr_enable_80");
        busRead(2'd0, 32'h80, "force_pending");
        checkOutput("force_irq_req", {31'd0, irq_req}, 32'd1);
        checkOutput("force_irq_id",  {29'd0, irq_id},  32'd7);
        busRead(2'd3, 32'h00, "force_reads_zero");
        busRead(2'd2, 32'h8000_0007, "force_active");
        idle(2);

        // Asynchronous reset during SERVICE, source held high across release
        ackOnce();
        checkOutput("pre_reset_service_id", {29'd0, irq_id}, 32'd7);
        idle(2);
        #2;
        rst_n  = 1'b0;
        src_in = 8'h40;
        #1;
        checkOutput("async_rst_irq_req",   {31'd0, irq_req},   32'd0);
        checkOutput("async_rst_irq_id",    {29'd0, irq_id},    32'd0);
        checkOutput("async_rst_bus_ready", {31'd0, bus_ready}, 32'd0);
        checkOutput("async_rst_bus_rdata", bus_rdata,          32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        idle(5);
        busRead(2'd0, 32'h40, "post_reset_one_capture");
        busRead(2'd1, 32'h00, "post_reset_enable");
        busRead(2'd2, 32'h00, "post_reset_active");
        checkOutput("post_reset_irq_req", {31'd0, irq_req}, 32'd0);
        busWrite(2'd0, 32'h40, "w1c_src6");
        idle(4);
        busRead(2'd0, 32'h00, "post_reset_no_second_capture");
        src_in = 8'h00;

        // Drain the scoreboard within a bounded number of cycles
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
